// File: rtl/int_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Accepts one division from ID/EX and holds busy while it iterates.
// Finishes with a one-cycle div_done pulse carrying the result and the
// captured destination register. Division by zero and signed overflow
// bypass the iteration and finish two cycles after the start.
module int_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            IDiv,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      id_ex_rd,
  input  logic            flush,
  output logic            busy,
  output logic            div_done,
  output logic [XLEN-1:0] div_result,
  output logic [4:0]      div_rd
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q;
  logic              rem_sel_q;   // 1: return remainder, 0: return quotient
  logic [XLEN-1:0]   dsr_q;       // divisor magnitude
  logic [XLEN-1:0]   quo_q;       // dividend shifts out, quotient shifts in
  logic [XLEN-1:0]   rem_q;       // partial remainder
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;

  // Start-time decode: operand signs, magnitudes and special cases.
  logic            is_signed;
  logic            dvd_neg;
  logic            dsr_neg;
  logic [XLEN-1:0] dvd_abs;
  logic [XLEN-1:0] dsr_abs;
  logic            div_by_zero;
  logic            overflow;

  // Restoring step and end-of-operation sign correction.
  logic [XLEN:0]   shifted_d;
  logic [XLEN:0]   trial_d;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] quo_fix_d;
  logic [XLEN-1:0] rem_fix_d;

  // Combinational operand decode, one datapath step and the final fixup.
  // NOTE: every output is assigned unconditionally here, so no latch can be inferred.
  always_comb begin
    is_signed   = ~div_op[0];
    dvd_neg     = is_signed & dividend[XLEN-1];
    dsr_neg     = is_signed & divisor[XLEN-1];
    dvd_abs     = dvd_neg ? (~dividend + 1'b1) : dividend;
    dsr_abs     = dsr_neg ? (~divisor + 1'b1) : divisor;
    div_by_zero = (divisor == '0);
    overflow    = is_signed && (dividend == INT_MIN) && (divisor == '1);

    // Shift {rem,quo} left by one; the trial subtraction borrows out of
    // bit XLEN exactly when the shifted remainder is below the divisor.
    shifted_d = {rem_q, quo_q[XLEN-1]};
    trial_d   = shifted_d - {1'b0, dsr_q};
    rem_d     = trial_d[XLEN] ? shifted_d[XLEN-1:0] : trial_d[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], ~trial_d[XLEN]};

    quo_fix_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      dsr_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (IDiv) begin
              rem_sel_q <= div_op[1];
              rd_q      <= id_ex_rd;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              dsr_q     <= dsr_abs;
              if (div_by_zero) begin
                quo_q     <= '1;
                rem_q     <= dividend;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
                state_q   <= FINISH;
              end else if (overflow) begin
                quo_q     <= INT_MIN;
                rem_q     <= '0;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
                state_q   <= FINISH;
              end else begin
                quo_q     <= dvd_abs;
                rem_q     <= '0;
                neg_quo_q <= dvd_neg ^ dsr_neg;
                neg_rem_q <= dvd_neg;
                state_q   <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) state_q <= FINISH;
          end
          FINISH: begin
            result_q <= rem_sel_q ? rem_fix_d : quo_fix_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign div_done   = done_q;
  assign div_result = result_q;
  assign div_rd     = rd_q;

endmodule

// File: tb/tb_int_div_unit.sv
// Self-checking bench for int_div_unit: directed RV32M corner cases,
// randomized operations against an arithmetic reference model, flush,
// ignored restarts, back-to-back issue and mid-operation reset.
module tb_int_div_unit;

  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            rst;
  logic            IDiv;
  logic [1:0]      div_op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [4:0]      id_ex_rd;
  logic            flush;
  logic            busy;
  logic            div_done;
  logic [XLEN-1:0] div_result;
  logic [4:0]      div_rd;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  int_div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .IDiv      (IDiv),
    .div_op    (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .id_ex_rd  (id_ex_rd),
    .flush     (flush),
    .busy      (busy),
    .div_done  (div_done),
    .div_result(div_result),
    .div_rd    (div_rd)
  );

  always #5 CLK = ~CLK;

  // Reference: RISC-V M-extension semantics using plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) begin
      sa = a;
      sb = b;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return XLEN + 2;
  endfunction

  // Present a start request; the caller is at a falling edge (cycle 0).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    IDiv     = 1'b1;
    div_op   = op;
    dividend = a;
    divisor  = b;
    id_ex_rd = rd;
  endtask

  // Follow one division from cycle 1 to its done cycle, stopping at that
  // cycle's falling edge so a new request may be issued there.
  task automatic expect_run(input string name, input int lat, input logic [31:0] res,
                            input logic [4:0] rd);
    bit phase_bad = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge CLK);
      if (c == 1) IDiv = 1'b0;
      if (c < lat && (busy !== 1'b1 || div_done !== 1'b0) && !phase_bad) begin
        phase_bad = 1'b1;
        $display("FAIL %s busy_phase cycle=%0d busy=%b done=%b expected busy=1 done=0",
                 name, c, busy, div_done);
      end
    end
    checks++;
    if (phase_bad) failures++;
    checks++;
    if (div_done !== 1'b1 || busy !== 1'b0 || div_result !== res || div_rd !== rd) begin
      failures++;
      $display("FAIL %s done_cycle=%0d got done=%b busy=%b result=%h rd=%0d expected done=1 busy=0 result=%h rd=%0d",
               name, lat, div_done, busy, div_result, div_rd, res, rd);
    end
  endtask

  // The pulse lasts one cycle and the result stays put afterwards.
  task automatic expect_hold(input string name, input logic [31:0] res, input logic [4:0] rd);
    @(negedge CLK);
    checks++;
    if (div_done !== 1'b0 || busy !== 1'b0 || div_result !== res || div_rd !== rd) begin
      failures++;
      $display("FAIL %s hold got done=%b busy=%b result=%h rd=%0d expected done=0 busy=0 result=%h rd=%0d",
               name, div_done, busy, div_result, div_rd, res, rd);
    end
  endtask

  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp_res;
    exp_res = ref_result(op, a, b);
    issue(op, a, b, rd);
    expect_run(name, ref_latency(op, a, b), exp_res, rd);
    expect_hold(name, exp_res, rd);
  endtask

  task automatic expect_no_done(input string name, input int ncycles);
    bit seen = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge CLK);
      if (div_done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL %s spurious div_done within %0d cycles", name, ncycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || div_done !== 1'b0 || div_result !== '0 || div_rd !== '0) begin
      failures++;
      $display("FAIL reset got busy=%b done=%b result=%h rd=%0d expected all zero",
               busy, div_done, div_result, div_rd);
    end
    rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    run_one("div_100_7",   OP_DIV,  32'd100, 32'd7, 5'd5);
    run_one("rem_100_7",   OP_REM,  32'd100, 32'd7, 5'd6);
    run_one("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd7);
    run_one("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd8);
    run_one("remu_big_2",  OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_one("divu_big_2",  OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_one("divu_by0",    OP_DIVU, 32'd1234, 32'd0, 5'd11);
    run_one("rem_by0",     OP_REM,  32'd1234, 32'd0, 5'd12);
    run_one("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    run_one("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    run_one("divu_nonovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_one("div_7_m100",  OP_DIV,  32'd7, 32'hFFFF_FF9C, 5'd16);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (i == 3) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_one("random", op, a, b, 5'($urandom_range(1, 31)));
    end
  endtask

  task automatic test_flush();
    issue(OP_DIV, 32'd100, 32'd7, 5'd5);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 1) IDiv = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge CLK);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || div_done !== 1'b0) begin
      failures++;
      $display("FAIL flush got busy=%b done=%b expected busy=0 done=0", busy, div_done);
    end
    expect_no_done("flush_no_done", 40);
    run_one("after_flush_9_3", OP_DIV, 32'd9, 32'd3, 5'd3);
    // Flush and start on the same edge: the start must lose.
    issue(OP_DIVU, 32'd50, 32'd5, 5'd20);
    flush = 1'b1;
    @(negedge CLK);
    IDiv  = 1'b0;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_priority got busy=%b expected 0", busy);
    end
    expect_no_done("flush_priority_no_done", 40);
  endtask

  task automatic test_back_to_back();
    issue(OP_DIV, 32'd100, 32'd7, 5'd5);
    for (int c = 1; c <= XLEN + 2; c++) begin
      @(negedge CLK);
      if (c == 1 || c == 6) IDiv = 1'b0;
      if (c == 5) issue(OP_DIVU, 32'd55, 32'd5, 5'd9);
    end
    checks++;
    if (div_done !== 1'b1 || div_result !== 32'd14 || div_rd !== 5'd5) begin
      failures++;
      $display("FAIL ignore_restart got done=%b result=%h rd=%0d expected done=1 result=0000000e rd=5",
               div_done, div_result, div_rd);
    end
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd12);
    expect_run("back_to_back", XLEN + 2, 32'd100, 5'd12);
    expect_hold("back_to_back", 32'd100, 5'd12);
  endtask

  task automatic test_rst_mid();
    issue(OP_DIV, 32'd100, 32'd7, 5'd5);
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (c == 1) IDiv = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(negedge CLK);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || div_done !== 1'b0 || div_result !== '0 || div_rd !== '0) begin
      failures++;
      $display("FAIL rst_mid got busy=%b done=%b result=%h rd=%0d expected all zero",
               busy, div_done, div_result, div_rd);
    end
    expect_no_done("rst_mid_no_done", 40);
  endtask

  initial begin
    rst      = 1'b1;
    IDiv     = 1'b0;
    div_op   = 2'b00;
    dividend = '0;
    divisor  = '0;
    id_ex_rd = '0;
    flush    = 1'b0;
    @(negedge CLK);
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
